// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM states
// and the cycles-per-product calculation.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns 0 when bpc does not divide bw, which the top turns into an elaboration error.
    function automatic int calc_n(input int bw, input int bpc);
        if (bpc < 1 || bpc > bw || (bw % bpc) != 0)
            return 0;
        return bw / bpc;
    endfunction

endpackage

// File: rtl/prefix_adder.sv
// Parametrised Kogge-Stone prefix adder (no carry-in, carry-out discarded).
module prefix_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    // Generate/propagate are combined in place; walking i downward keeps i-d at its previous-level value.
    function automatic logic [W-1:0] ks_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W-1:0] p0;
        g  = x & y;
        p  = x ^ y;
        p0 = p;
        for (int d = 1; d < W; d = d * 2) begin
            for (int i = W - 1; i >= d; i--) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        return p0 ^ {g[W-2:0], 1'b0};
    endfunction

    assign sum = ks_add(a, b);

endmodule

// File: rtl/seq_mul_step.sv
// One shift-add iteration: adds magnitude * chunk to the upper accumulator
// slice, producing a BW+BPC bit partial sum with its carry retained.
module seq_mul_step #(
    parameter int BW  = 16,
    parameter int BPC = 4
) (
    input  logic [BW-1:0]     mag,
    input  logic [BPC-1:0]    chunk,
    input  logic [BW-1:0]     acc_hi,
    output logic [BW+BPC-1:0] sum
);

    logic [BW+BPC-1:0] pp;
    logic [BW+BPC-1:0] hi_ext;

    assign pp     = (BW+BPC)'(mag) * (BW+BPC)'(chunk);
    assign hi_ext = {{BPC{1'b0}}, acc_hi};

    prefix_adder #(
        .W (BW + BPC)
    ) u_add (
        .a   (pp),
        .b   (hi_ext),
        .sum (sum)
    );

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned shift-add multiplier consuming BPC multiplier
// bits per cycle, with valid/ready handshakes on input and output.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int BW  = 16,
    parameter int BPC = 4
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BW-1:0]   A,
    input  logic [BW-1:0]   B,
    input  logic            signed_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*BW-1:0] out
);

    localparam int N  = calc_n(BW, BPC);
    localparam int CW = $clog2(N + 1);

    if (N == 0) begin : g_bad_bpc
        $error("seq_multiplier: BPC must be in 1..BW and divide BW");
    end

    state_t              state;
    logic [2*BW-1:0]     acc;
    logic [2*BW-1:0]     acc_next;
    logic [CW-1:0]       count;
    logic                sign;
    logic                last;
    logic [BW-1:0]       a_mag;
    logic [BW-1:0]       b_rem;
    logic [BW-1:0]       a_abs;
    logic [BW-1:0]       b_abs;
    logic [BW-1:0]       b_next;
    logic [BW+BPC-1:0]   b_ext;
    logic [BW+BPC-1:0]   part;
    logic [2*BW+BPC-1:0] wide;

    // Magnitudes at capture; -2^(BW-1) maps to 2^(BW-1), which still fits unsigned.
    assign a_abs = (signed_mode && A[BW-1]) ? -A : A;
    assign b_abs = (signed_mode && B[BW-1]) ? -B : B;

    assign b_ext  = {{BPC{1'b0}}, b_rem};
    assign b_next = BW'(b_ext >> BPC);

    seq_mul_step #(
        .BW  (BW),
        .BPC (BPC)
    ) u_step (
        .mag    (a_mag),
        .chunk  (b_rem[BPC-1:0]),
        .acc_hi (acc[2*BW-1:BW]),
        .sum    (part)
    );

    // Partial sum replaces the upper half, then the whole accumulator slides right by BPC.
    assign wide     = {part, acc[BW-1:0]};
    assign acc_next = (2*BW)'(wide >> BPC);
    assign last     = (count == CW'(N - 1));

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            acc       <= '0;
            count     <= '0;
            sign      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        acc      <= '0;
                        count    <= '0;
                        sign     <= signed_mode & (A[BW-1] ^ B[BW-1]);
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out       <= sign ? -acc_next : acc_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Operand registers carry no reset; they are always reloaded at accept.
    always_ff @(posedge CLK) begin
        if (state == IDLE && in_valid) begin
            a_mag <= a_abs;
            b_rem <= b_abs;
        end else if (state == BUSY) begin
            b_rem <= b_next;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: three multiplier instances (BPC=4, 1, 16) checked
// against an integer-arithmetic reference model.
module tb_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [2:0]  smode;
    logic [15:0] a_in [3];
    logic [15:0] b_in [3];
    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [31:0] prod [3];

    int n_cmp;
    int n_bad;

    seq_multiplier #(.BW(16), .BPC(4)) dut4 (
        .CLK(clk), .RESETn(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a_in[0]), .B(b_in[0]), .signed_mode(smode[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out(prod[0]));

    seq_multiplier #(.BW(16), .BPC(1)) dut1 (
        .CLK(clk), .RESETn(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a_in[1]), .B(b_in[1]), .signed_mode(smode[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out(prod[1]));

    seq_multiplier #(.BW(16), .BPC(16)) dut16 (
        .CLK(clk), .RESETn(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(a_in[2]), .B(b_in[2]), .signed_mode(smode[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out(prod[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        longint x;
        longint y;
        longint p;
        x = s ? longint'($signed(a)) : longint'({48'd0, a});
        y = s ? longint'($signed(b)) : longint'({48'd0, b});
        p = x * y;
        return p[31:0];
    endfunction

    function automatic logic [15:0] pick_operand();
        logic [15:0] corners [5];
        corners = '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001};
        if ($urandom_range(0, 5) == 0)
            return corners[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || prod[k] !== 32'd0) begin
                n_bad++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out=%h, want 1 0 00000000",
                         k, in_ready[k], out_valid[k], prod[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vs [6];
        logic [31:0] ve [6];
        int          lat;
        va = '{16'hFFFF, 16'h8000, 16'hFFFD, 16'h0000, 16'h8000, 16'h7FFF};
        vb = '{16'hFFFF, 16'h8000, 16'h0005, 16'h8000, 16'h0001, 16'h8000};
        vs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ve = '{32'hFFFE0001, 32'h40000000, 32'hFFFFFFF1, 32'h00000000, 32'hFFFF8000, 32'hC0008000};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_in[0] = va[i]; b_in[0] = vb[i]; smode[0] = vs[i];
            in_valid[0] = 1'b1; out_ready[0] = 1'b1;
            @(posedge clk);
            #1;
            in_valid[0] = 1'b0;
            lat = 0;
            while (out_valid[0] !== 1'b1 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            n_cmp++;
            if (lat != 4) begin
                n_bad++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, want 4", i, lat);
            end
            n_cmp++;
            if (prod[0] !== ve[i]) begin
                n_bad++;
                $display("FAIL directed_product[%0d]: got %h, want %h", i, prod[0], ve[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pa, pb;
        logic        pm;
        logic [31:0] exp0, exp1;
        int          lat;
        @(negedge clk);
        a_in[0] = 16'hBEEF; b_in[0] = 16'h1234; smode[0] = 1'b1;
        exp0 = ref_mul(16'hBEEF, 16'h1234, 1'b1);
        in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        lat = 0;
        // Operands churn while BUSY; the captured pair must still win.
        while (out_valid[0] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            a_in[0] = 16'($urandom); b_in[0] = 16'($urandom); smode[0] = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat != 4 || prod[0] !== exp0) begin
            n_bad++;
            $display("FAIL bp_first: lat=%0d out=%h, want lat=4 out=%h", lat, prod[0], exp0);
        end
        pa = pick_operand(); pb = pick_operand(); pm = 1'($urandom);
        exp1 = ref_mul(pa, pb, pm);
        @(negedge clk);
        a_in[0] = pa; b_in[0] = pb; smode[0] = pm;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid[0] !== 1'b1 || prod[0] !== exp0 || in_ready[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: out_valid=%b out=%h in_ready=%b, want 1 %h 0",
                         c, out_valid[0], prod[0], in_ready[0], exp0);
            end
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || prod[0] !== exp0) begin
            n_bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b out=%h, want 0 1 %h",
                     out_valid[0], in_ready[0], prod[0], exp0);
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        n_cmp++;
        if (in_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_accept: in_ready=%b, want 0", in_ready[0]);
        end
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat != 4 || prod[0] !== exp1) begin
            n_bad++;
            $display("FAIL bp_pending: lat=%0d out=%h, want lat=4 out=%h", lat, prod[0], exp1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        a_in[0] = 16'h1234; b_in[0] = 16'h00FF; smode[0] = 1'b0;
        in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (prod[0] !== 32'd0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset: out=%h out_valid=%b in_ready=%b, want 00000000 0 1",
                     prod[0], out_valid[0], in_ready[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_in[0] = 16'd3; b_in[0] = 16'd7; smode[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat != 4 || prod[0] !== 32'h00000015) begin
            n_bad++;
            $display("FAIL after_reset: lat=%0d out=%h, want lat=4 out=00000015", lat, prod[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep(input int k, input int n);
        logic [15:0] a, b;
        logic        s;
        logic [31:0] e;
        int          lat;
        out_ready[k] = 1'b1;
        for (int it = 0; it < 1000; it++) begin
            a = pick_operand(); b = pick_operand(); s = 1'($urandom);
            e = ref_mul(a, b, s);
            @(negedge clk);
            n_cmp++;
            if (in_ready[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL sweep%0d_ready[%0d]: in_ready=%b, want 1", n, it, in_ready[k]);
            end
            a_in[k] = a; b_in[k] = b; smode[k] = s; in_valid[k] = 1'b1;
            @(posedge clk);
            #1;
            in_valid[k] = 1'b0;
            lat = 0;
            while (out_valid[k] !== 1'b1 && lat < n + 8) begin
                @(posedge clk);
                #1;
                lat++;
            end
            n_cmp++;
            if (lat != n) begin
                n_bad++;
                $display("FAIL sweep%0d_latency[%0d]: got %0d, want %0d", n, it, lat, n);
            end
            n_cmp++;
            if (prod[k] !== e) begin
                n_bad++;
                $display("FAIL sweep%0d_product[%0d]: %h*%h s=%b got %h, want %h",
                         n, it, a, b, s, prod[k], e);
            end
            @(posedge clk);
            #1;
            if (out_valid[k] !== 1'b0) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '0;
        smode = '0;
        for (int k = 0; k < 3; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_sweep(1, 16);
        test_sweep(2, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
